// File: rtl/wb_pkg.sv
// Shared Wishbone master types and widths: FSM state encoding and bus field sizes.
package wb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;
    localparam int TMO_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQUEST  = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

endpackage : wb_pkg

// File: rtl/wb_master.sv
// Single-transaction Wishbone B4 pipelined master with a cycle timeout.
// The core side hands over one request while ready_o=1. The block then runs
// one bus cycle and reports the end of it with a done_o pulse. err_o is set
// on that pulse when the cycle was abandoned because the slave never acked.
module wb_master
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // core side
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              ready_o,
    output logic              done_o,
    output logic              err_o,
    output logic [DATA_W-1:0] rdata_o,
    // Wishbone side
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic              wb_we_o,
    output logic [SEL_W-1:0]  wb_sel_o,
    output logic              wb_stb_o,
    output logic              wb_cyc_o,
    input  logic              wb_ack_i,
    input  logic              wb_stall_i
);

    // Last counter value a transaction may reach before it is abandoned.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             cyc_d, stb_d, done_d, err_d;
    logic             load_req;    // take the core request onto the bus registers
    logic             capture_rd;  // latch slave read data into rdata_o
    logic             tmo_hit;

    assign tmo_hit = (tmo_cnt_q == TMO_LAST);

    // Only output decoded from state: it lets the core see acceptance this cycle.
    assign ready_o = (state_q == ST_IDLE);

    // Next-state and next-output decode. An ack is honoured before the timeout.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d    = state_q;
        tmo_cnt_d  = tmo_cnt_q;
        cyc_d      = wb_cyc_o;
        stb_d      = wb_stb_o;
        done_d     = 1'b0;
        err_d      = 1'b0;
        load_req   = 1'b0;
        capture_rd = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    load_req  = 1'b1;
                    tmo_cnt_d = '0;
                    cyc_d     = 1'b1;
                    stb_d     = 1'b1;
                    state_d   = ST_REQUEST;
                end
            end

            ST_REQUEST: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                // While stalled, the slave has not taken the strobe, so any ack is not ours.
                if (!wb_stall_i && wb_ack_i) begin
                    cyc_d      = 1'b0;
                    stb_d      = 1'b0;
                    done_d     = 1'b1;
                    capture_rd = !wb_we_o;
                    state_d    = ST_IDLE;
                end else if (tmo_hit) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (!wb_stall_i) begin
                    stb_d   = 1'b0;
                    state_d = ST_WAIT_ACK;
                end
            end

            ST_WAIT_ACK: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                if (wb_ack_i) begin
                    cyc_d      = 1'b0;
                    stb_d      = 1'b0;
                    done_d     = 1'b1;
                    capture_rd = !wb_we_o;
                    state_d    = ST_IDLE;
                end else if (tmo_hit) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, control outputs and timeout counter. Reset drops the bus at once
    // and emits no done_o for whatever was in flight.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments make every register update from pre-edge values, so ordering inside the block does not matter.
        if (rst_i) begin
            state_q   <= ST_IDLE;
            tmo_cnt_q <= '0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            wb_cyc_o  <= cyc_d;
            wb_stb_o  <= stb_d;
            done_o    <= done_d;
            err_o     <= err_d;
        end
    end

    // Bus fields and read data. These hold their value between transactions.
    always_ff @(posedge clk_i) begin
        // NOTE: the datapath registers are reset too, because the bus fields and rdata_o must read zero after reset.
        if (rst_i) begin
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            rdata_o  <= '0;
        end else begin
            if (load_req) begin
                wb_adr_o <= addr_i;
                wb_dat_o <= wdata_i;
                wb_we_o  <= we_i;
                wb_sel_o <= sel_i;
            end
            if (capture_rd) begin
                rdata_o <= wb_dat_i;
            end
        end
    end

endmodule : wb_master

// File: tb/tb_wb_master.sv
// Directed bench for wb_master: one table of per-edge vectors plus hand-written
// timeout and ack-at-timeout sequences.
module tb_wb_master;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic [31:0] wdata_i;
    logic        ready_o, done_o, err_o;
    logic [31:0] rdata_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i, wb_stall_i;
    logic [3:0]  wb_sel_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    wb_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .addr_i     (addr_i),
        .we_i       (we_i),
        .sel_i      (sel_i),
        .wdata_i    (wdata_i),
        .ready_o    (ready_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .rdata_o    (rdata_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_stb_o   (wb_stb_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_ack_i   (wb_ack_i),
        .wb_stall_i (wb_stall_i)
    );

    // One clock edge: inputs held across the edge, outputs expected just after it.
    typedef struct {
        logic        rst, req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic        stall, ack;
        logic [31:0] dat;
        logic        e_ready, e_cyc, e_stb, e_done, e_err;
        logic [31:0] e_rdata, e_adr, e_wdat;
        logic [3:0]  e_sel;
        logic        e_we;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst, req, input logic [31:0] addr, input logic we, input logic [3:0] sel,
        input logic [31:0] wdata, input logic stall, ack, input logic [31:0] dat,
        input logic e_ready, e_cyc, e_stb, e_done, e_err,
        input logic [31:0] e_rdata, e_adr, e_wdat, input logic [3:0] e_sel, input logic e_we);
        vec_t v;
        v.rst = rst; v.req = req; v.addr = addr; v.we = we; v.sel = sel; v.wdata = wdata;
        v.stall = stall; v.ack = ack; v.dat = dat;
        v.e_ready = e_ready; v.e_cyc = e_cyc; v.e_stb = e_stb; v.e_done = e_done; v.e_err = e_err;
        v.e_rdata = e_rdata; v.e_adr = e_adr; v.e_wdat = e_wdat; v.e_sel = e_sel; v.e_we = e_we;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, req, input logic [31:0] addr, input logic we,
                         input logic [3:0] sel, input logic [31:0] wdata,
                         input logic stall, ack, input logic [31:0] dat);
        rst_i = rst; req_i = req; addr_i = addr; we_i = we; sel_i = sel; wdata_i = wdata;
        wb_stall_i = stall; wb_ack_i = ack; wb_dat_i = dat;
    endtask

    task automatic apply(input string tag, input vec_t v);
        @(negedge clk_i);
        drive(v.rst, v.req, v.addr, v.we, v.sel, v.wdata, v.stall, v.ack, v.dat);
        @(posedge clk_i);
        #1;
        check({tag, " ready"}, 32'(ready_o), 32'(v.e_ready));
        check({tag, " cyc"},   32'(wb_cyc_o), 32'(v.e_cyc));
        check({tag, " stb"},   32'(wb_stb_o), 32'(v.e_stb));
        check({tag, " done"},  32'(done_o),   32'(v.e_done));
        check({tag, " err"},   32'(err_o),    32'(v.e_err));
        check({tag, " rdata"}, rdata_o,       v.e_rdata);
        check({tag, " adr"},   wb_adr_o,      v.e_adr);
        check({tag, " wdat"},  wb_dat_o,      v.e_wdat);
        check({tag, " sel"},   32'(wb_sel_o), 32'(v.e_sel));
        check({tag, " we"},    32'(wb_we_o),  32'(v.e_we));
    endtask

    initial begin
        int   hi_cycles;
        logic dropped;

        drive(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0);

        //           rst req addr          we sel    wdata         st ack dat              rdy cyc stb dn er rdata         adr           wdat          sel    we
        // reset, then spurious ack in IDLE
        vecs.push_back(mk(1, 0, 32'h0,        0, 4'h0, 32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        4'h0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0,        0, 1, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        4'h0, 0));
        // zero-wait read
        vecs.push_back(mk(0, 1, 32'h10,       0, 4'hF, 32'h0,        0, 0, 32'h0,        0, 1, 1, 0, 0, 32'h0,        32'h10,       32'h0,        4'hF, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0,        0, 0, 32'h0,        0, 1, 0, 0, 0, 32'h0,        32'h10,       32'h0,        4'hF, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0,        0, 1, 32'hDEAD_BEEF, 1, 0, 0, 1, 0, 32'hDEAD_BEEF, 32'h10,       32'h0,        4'hF, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 0, 32'hDEAD_BEEF, 32'h10,       32'h0,        4'hF, 0));
        // stalled write, spurious ack while stalled, ack on the first unstalled edge
        vecs.push_back(mk(0, 1, 32'h20,       1, 4'h3, 32'h1234_5678, 0, 0, 32'h0,        0, 1, 1, 0, 0, 32'hDEAD_BEEF, 32'h20,       32'h1234_5678, 4'h3, 1));
        vecs.push_back(mk(0, 0, 32'hFFFF_0000, 0, 4'hF, 32'hFFFF_FFFF, 1, 0, 32'h0,        0, 1, 1, 0, 0, 32'hDEAD_BEEF, 32'h20,       32'h1234_5678, 4'h3, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0,        1, 1, 32'h0,        0, 1, 1, 0, 0, 32'hDEAD_BEEF, 32'h20,       32'h1234_5678, 4'h3, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0,        1, 0, 32'h0,        0, 1, 1, 0, 0, 32'hDEAD_BEEF, 32'h20,       32'h1234_5678, 4'h3, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0,        0, 1, 32'h9999_9999, 1, 0, 0, 1, 0, 32'hDEAD_BEEF, 32'h20,       32'h1234_5678, 4'h3, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 0, 32'hDEAD_BEEF, 32'h20,       32'h1234_5678, 4'h3, 1));
        // back-to-back reads with req_i held high
        vecs.push_back(mk(0, 1, 32'h30,       0, 4'hF, 32'h0,        0, 0, 32'h0,        0, 1, 1, 0, 0, 32'hDEAD_BEEF, 32'h30,       32'h0,        4'hF, 0));
        vecs.push_back(mk(0, 1, 32'h40,       0, 4'hF, 32'h0,        0, 0, 32'h0,        0, 1, 0, 0, 0, 32'hDEAD_BEEF, 32'h30,       32'h0,        4'hF, 0));
        vecs.push_back(mk(0, 1, 32'h40,       0, 4'hF, 32'h0,        0, 1, 32'hCAFE_F00D, 1, 0, 0, 1, 0, 32'hCAFE_F00D, 32'h30,       32'h0,        4'hF, 0));
        vecs.push_back(mk(0, 1, 32'h40,       0, 4'hF, 32'h0,        0, 0, 32'h0,        0, 1, 1, 0, 0, 32'hCAFE_F00D, 32'h40,       32'h0,        4'hF, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0,        0, 1, 32'h1111_2222, 1, 0, 0, 1, 0, 32'h1111_2222, 32'h40,       32'h0,        4'hF, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 0, 32'h1111_2222, 32'h40,       32'h0,        4'hF, 0));
        // reset in WAIT_ACK, then a late ack that must be ignored
        vecs.push_back(mk(0, 1, 32'h50,       1, 4'hC, 32'hA5A5_A5A5, 0, 0, 32'h0,        0, 1, 1, 0, 0, 32'h1111_2222, 32'h50,       32'hA5A5_A5A5, 4'hC, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0,        0, 0, 32'h0,        0, 1, 0, 0, 0, 32'h1111_2222, 32'h50,       32'hA5A5_A5A5, 4'hC, 1));
        vecs.push_back(mk(1, 0, 32'h0,        0, 4'h0, 32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        4'h0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0,        0, 1, 32'h7777_7777, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        4'h0, 0));
        // read that seeds rdata_o before the timeout sequence
        vecs.push_back(mk(0, 1, 32'h60,       0, 4'hF, 32'h0,        0, 0, 32'h0,        0, 1, 1, 0, 0, 32'h0,        32'h60,       32'h0,        4'hF, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0,        0, 0, 32'h0,        0, 1, 0, 0, 0, 32'h0,        32'h60,       32'h0,        4'hF, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0,        0, 1, 32'h0BAD_CAFE, 1, 0, 0, 1, 0, 32'h0BAD_CAFE, 32'h60,       32'h0,        4'hF, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 0, 32'h0BAD_CAFE, 32'h60,       32'h0,        4'hF, 0));

        foreach (vecs[i]) apply($sformatf("row%0d", i), vecs[i]);

        // Timeout: slave never acks; cyc must stay high for 16 cycles from entry to REQUEST.
        apply("tmo accept", mk(0, 1, 32'h70, 0, 4'hF, 32'h0, 0, 0, 32'h0,
                               0, 1, 1, 0, 0, 32'h0BAD_CAFE, 32'h70, 32'h0, 4'hF, 0));
        hi_cycles = 1;
        dropped   = 1'b0;
        for (int i = 0; i < 40 && !dropped; i++) begin
            @(negedge clk_i);
            drive(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
            @(posedge clk_i);
            #1;
            if (wb_cyc_o) hi_cycles++;
            else dropped = 1'b1;
        end
        check("tmo cyc dropped",  32'(dropped),  32'd1);
        check("tmo cyc cycles",   32'(hi_cycles), 32'd16);
        check("tmo stb",          32'(wb_stb_o), 32'd0);
        check("tmo done",         32'(done_o),   32'd1);
        check("tmo err",          32'(err_o),    32'd1);
        check("tmo rdata held",   rdata_o,       32'h0BAD_CAFE);
        apply("tmo after", mk(0, 0, 32'h0, 0, 4'h0, 32'h0, 0, 0, 32'h0,
                              1, 0, 0, 0, 0, 32'h0BAD_CAFE, 32'h70, 32'h0, 4'hF, 0));

        // Ack arriving exactly on the timeout edge wins: done without err.
        apply("race accept", mk(0, 1, 32'h80, 0, 4'hF, 32'h0, 0, 0, 32'h0,
                                0, 1, 1, 0, 0, 32'h0BAD_CAFE, 32'h80, 32'h0, 4'hF, 0));
        for (int i = 1; i < 16; i++) begin
            apply($sformatf("race wait%0d", i), mk(0, 0, 32'h0, 0, 4'h0, 32'h0, 0, 0, 32'h0,
                                                   0, 1, 0, 0, 0, 32'h0BAD_CAFE, 32'h80, 32'h0, 4'hF, 0));
        end
        apply("race ack", mk(0, 0, 32'h0, 0, 4'h0, 32'h0, 0, 1, 32'h1357_2468,
                             1, 0, 0, 1, 0, 32'h1357_2468, 32'h80, 32'h0, 4'hF, 0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_wb_master

// File: doc/wb_master.md
WB_MASTER -- requirements
Module: wb_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, the number of cycles an outstanding transaction may remain open before it is aborted; legal range 2..65535.
REQ-002 clk_i  input  1  Single clock; all logic is rising-edge triggered.
REQ-003 rst_i  input  1  Reset; synchronous and active-high.
REQ-004 req_i  input  1  Request strobe from the core side; sampled only while ready_o=1.
REQ-005 addr_i  input  32  Request address.
REQ-006 we_i  input  1  Request direction: 1=write, 0=read.
REQ-007 sel_i  input  4  Byte-lane select for the request.
REQ-008 wdata_i  input  32  Write data for the request.
REQ-009 ready_o  output  1  Block is idle and will accept req_i.
REQ-010 done_o  output  1  One-cycle pulse marking the end of a transaction.
REQ-011 err_o  output  1  Qualifies done_o: the transaction ended by timeout.
REQ-012 rdata_o  output  32  Read data captured on ack; held until the next read completes.
REQ-013 wb_adr_o, wb_dat_o (32), wb_dat_i (32), wb_we_o (1), wb_sel_o (4), wb_stb_o (1), wb_cyc_o (1), wb_ack_i (1), wb_stall_i (1)  Wishbone B4 pipelined master port.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, REQUEST and WAIT_ACK, and at most one transaction SHALL be outstanding at any time.
REQ-015 ready_o SHALL be 1 exactly when state=IDLE; req_i SHALL be ignored in every other state.
REQ-016 In IDLE, when req_i=1, the block SHALL:
- register addr_i, we_i, sel_i and wdata_i into wb_adr_o, wb_we_o, wb_sel_o and wb_dat_o;
- move to REQUEST;
- drive wb_cyc_o=wb_stb_o=1 from the next cycle.
REQ-017 In REQUEST, wb_stb_o SHALL stay 1 and the registered bus fields SHALL stay stable while wb_stall_i=1.
REQ-018 In REQUEST, on a clock edge with wb_stall_i=0:
- if wb_ack_i=0, the block SHALL deassert wb_stb_o, keep wb_cyc_o=1 and move to WAIT_ACK;
- if wb_ack_i=1 in that same edge, the block SHALL complete the transaction directly as in REQ-019.
REQ-019 On wb_ack_i=1 in WAIT_ACK, the block SHALL:
- deassert wb_cyc_o;
- pulse done_o=1 with err_o=0 in the following cycle;
- capture wb_dat_i into rdata_o for reads only;
- return to IDLE.
REQ-020 wb_ack_i SHALL be ignored in REQUEST while wb_stall_i=1, and in IDLE.
REQ-021 A 16-bit timeout counter SHALL:
- clear on entry to REQUEST;
- increment every cycle spent in REQUEST or WAIT_ACK.
When it reaches TIMEOUT_CYCLES-1 without completion, the block SHALL drop wb_cyc_o and wb_stb_o, pulse done_o=err_o=1, leave rdata_o unchanged and return to IDLE.
REQ-022 If an ack coincides with the timeout edge, the ack SHALL take precedence and err_o SHALL be 0.
REQ-023 All outputs except ready_o SHALL be registered.
REQ-024 Minimum latency: with req_i at edge N, stall=0 and ack sampled at edge N+2, done_o SHALL be high in the cycle following edge N+2.
REQ-025 A new req_i SHALL be accepted in the cycle in which done_o is high, giving back-to-back operation.

Reset
REQ-026 While rst_i=1 at a clock edge, the block SHALL set state=IDLE and clear wb_cyc_o, wb_stb_o, done_o, err_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o, rdata_o and the timeout counter to 0.
REQ-027 A reset asserted mid-transaction SHALL drop wb_cyc_o and wb_stb_o at that edge, and no done_o SHALL be produced for the aborted transaction.

Structure
REQ-028 The FSM state enumeration (IDLE/REQUEST/WAIT_ACK, 2-bit) SHALL reside in a shared package wb_pkg, together with the 32-bit address/data width and 4-bit select width constants.
REQ-029 The block SHALL be a single module with no sub-module.

Verification
REQ-030 Read with zero wait: req_i with addr_i=0x0000_0010 and we_i=0; slave stall=0, ack one cycle after stb with dat=0xDEAD_BEEF -> one stb cycle, rdata_o=0xDEAD_BEEF, done_o=1 and err_o=0 for exactly one cycle.
REQ-031 Stalled write: we_i=1, wdata_i=0x1234_5678, sel_i=0b0011; stall=1 for 3 cycles, then ack -> stb high for 4 cycles with wb_dat_o/wb_adr_o/wb_sel_o stable throughout, and rdata_o unchanged.
REQ-032 Timeout: TIMEOUT_CYCLES=16, slave never acks -> cyc drops 16 cycles after entry to REQUEST, done_o=err_o=1 for one cycle, and ready_o=1 the following cycle.
REQ-033 Back-to-back: req_i held high across two transactions -> the second stb starts one cycle after the first done_o, with no lost request.
REQ-034 Reset mid-op: rst_i pulsed while in WAIT_ACK -> cyc=stb=0 after that edge, no done_o pulse, and ready_o=1 after reset is released.
REQ-035 Spurious ack: wb_ack_i=1 while in IDLE, and while stall=1 in REQUEST -> no state change and no done_o.
